traffic_light_ctrl: RTL and testbench
=====================================

Name: traffic_light_ctrl

Overview:
Traffic-light phase controller for a two-road intersection: main road and side road. It sits directly downstream of the clock divider. It consumes the divider's square-wave output as a time base, edge-detects it on clk_in into one-cycle "step" pulses, and sequences the light phases. It also presents the remaining phase time for the seven-segment display stage.

Parameters:
CNT_W, 8, width of phase countdown and count_out
T_GREEN_MAIN, 30, minimum main-road green, in steps
T_GREEN_SIDE, 20, side-road green, in steps
T_YELLOW, 3, yellow duration, in steps (both roads)
T_ALLRED, 1, all-red clearance duration, in steps

Ports:
clk_in  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
tick_in  input  1  divided clock level from divider; synchronous to clk_in
side_req  input  1  side-road vehicle sensor, level, synchronous
night_mode  input  1  night flashing request (used only with TL_NIGHT_FLASH_EN)
main_light  output  3  {red,yellow,green} for main road, one-hot or all-zero
side_light  output  3  {red,yellow,green} for side road
count_out  output  CNT_W  remaining steps in current phase
state_out  output  3  current phase code

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk_in. All state lives in clk_in posedge flops.
- Reset values:
  - state = MG
  - cnt = T_GREEN_MAIN
  - tick_d = 0
  - side_pend = 0
  - flash_ph = 0
  - main_light = 3'b001
  - side_light = 3'b100
  - count_out = T_GREEN_MAIN
  - state_out = 0
- step = tick_in & ~tick_d, where tick_d is tick_in registered. There is exactly one step per tick_in rising edge.
- A tick_in already high in the first cycle after reset counts as a step.
- State codes: MG=0 (main G / side R), MY=1 (main Y / side R), AR1=2 (both R), SG=3 (main R / side G), SY=4 (main R / side Y), AR2=5 (both R), FLASH=6. Code 7 is unused and recovers to MG with cnt=T_GREEN_MAIN on the next clock.
- Lights and state_out are a pure decode of the state register, with no added latency. count_out = cnt.
- Phase timing:
  - On entering a phase, cnt loads that phase's duration T.
  - Each step with cnt>1 decrements cnt.
  - A step with cnt==1 ends the phase: on the same clock edge, state advances and cnt loads the next phase's T.
  - A phase therefore lasts exactly T steps, and count_out shows T..1.
- Sequence: MG -> MY -> AR1 -> SG -> SY -> AR2 -> MG. Durations: MY and SY use T_YELLOW; AR1 and AR2 use T_ALLRED.
- side_pend:
  - Set in any cycle where side_req==1.
  - Cleared on the clock edge that enters SG. Set wins over clear if both occur on the same edge.
- MG expiry:
  - If side_pend==0 at the step where cnt==1, stay in MG with cnt held at 1.
  - The first step with side_pend==1 then moves to MY.
- Steps with no clock enable have no effect. Without a step, state and cnt hold indefinitely.
- Reset mid-phase returns immediately (asynchronously) to the reset values above.
- All durations must be in the range 1 .. 2^CNT_W-1. Out-of-range values are a configuration error and are not checked in RTL.

Optional Feature:
Macro TL_NIGHT_FLASH_EN.
- Defined:
  - A step with night_mode==1 in any non-FLASH state enters FLASH, with cnt=0 and flash_ph=1.
  - In FLASH, each step toggles flash_ph.
  - main_light = side_light = {1'b0, flash_ph, 1'b0}.
  - count_out = 0.
  - A step with night_mode==0 in FLASH enters AR2 with cnt=T_ALLRED. The normal sequence resumes from there.
  - night_mode takes priority over a phase expiry on the same step.
- Undefined:
  - night_mode is ignored; the port remains.
  - FLASH is unreachable; flash_ph is absent.

Test Plan:
Common setup: T_GREEN_MAIN=3, T_GREEN_SIDE=2, T_YELLOW=2, T_ALLRED=1; tick_in toggles every 2 clk_in.
1. Reset, side_req held 1 -> state_out sequence 0,1,2,3,4,5,0. Phases last 3,2,1,2,2,1 steps. count_out in MG reads 3,2,1. Lights exactly as decoded, never green+green.
2. side_req=0 throughout -> MG held forever with count_out=1. Pulse side_req for 1 clk at step 10 -> MY entered on the next step, and side_pend clears on entering SG.
3. Hold tick_in constant high for 20 clocks -> exactly one step total. State and cnt frozen afterwards.
4. Assert rst_n=0 mid-SG for 1 clk, asynchronously -> outputs return immediately to main 001 / side 100 / count_out 3 / state_out 0, without waiting for a clock.
5. With TL_NIGHT_FLASH_EN: night_mode=1 during SG -> FLASH at next step, yellows toggle 010/000 per step, count_out=0. night_mode=0 -> AR2 for 1 step, then MG with count_out=3.
6. Without TL_NIGHT_FLASH_EN: repeat scenario 5 -> night_mode has no effect and state_out never reads 6.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic-light phase sequencer stepped by divider tick edges.
// Optional night flashing mode when TL_NIGHT_FLASH_EN is defined.
module traffic_light_ctrl #(
   parameter int CNT_W        = 8,
   parameter int T_GREEN_MAIN = 30,
   parameter int T_GREEN_SIDE = 20,
   parameter int T_YELLOW     = 3,
   parameter int T_ALLRED     = 1
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             tick_in,
   input  logic             side_req,
   input  logic             night_mode,
   output logic [2:0]       main_light,
   output logic [2:0]       side_light,
   output logic [CNT_W-1:0] count_out,
   output logic [2:0]       state_out
);

   typedef enum logic [2:0] {
      MG    = 3'd0,
      MY    = 3'd1,
      AR1   = 3'd2,
      SG    = 3'd3,
      SY    = 3'd4,
      AR2   = 3'd5,
      FLASH = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] TGM = CNT_W'(T_GREEN_MAIN);
   localparam logic [CNT_W-1:0] TGS = CNT_W'(T_GREEN_SIDE);
   localparam logic [CNT_W-1:0] TY  = CNT_W'(T_YELLOW);
   localparam logic [CNT_W-1:0] TA  = CNT_W'(T_ALLRED);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             tick_d;
   logic             side_pend, side_pend_n;
   logic             step;
   logic             last;

   assign step = tick_in & ~tick_d;
   assign last = cnt <= ONE;

`ifdef TL_NIGHT_FLASH_EN
   logic flash_ph, flash_ph_n;
`else
   logic unused_night;
   assign unused_night = night_mode;
`endif

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      side_pend_n = side_pend | side_req;
`ifdef TL_NIGHT_FLASH_EN
      flash_ph_n  = flash_ph;
`endif
      unique case (state)
         MG: if (step) begin
            if (!last) cnt_n = cnt - ONE;
            else if (side_pend) begin
               state_n = MY;
               cnt_n   = TY;
            end
         end
         MY: if (step) begin
            if (!last) cnt_n = cnt - ONE;
            else begin
               state_n = AR1;
               cnt_n   = TA;
            end
         end
         AR1: if (step) begin
            if (!last) cnt_n = cnt - ONE;
            else begin
               state_n = SG;
               cnt_n   = TGS;
            end
         end
         SG: if (step) begin
            if (!last) cnt_n = cnt - ONE;
            else begin
               state_n = SY;
               cnt_n   = TY;
            end
         end
         SY: if (step) begin
            if (!last) cnt_n = cnt - ONE;
            else begin
               state_n = AR2;
               cnt_n   = TA;
            end
         end
         AR2: if (step) begin
            if (!last) cnt_n = cnt - ONE;
            else begin
               state_n = MG;
               cnt_n   = TGM;
            end
         end
`ifdef TL_NIGHT_FLASH_EN
         FLASH: if (step) begin
            if (night_mode) flash_ph_n = ~flash_ph;
            else begin
               state_n = AR2;
               cnt_n   = TA;
            end
         end
`endif
         default: begin
            state_n = MG;
            cnt_n   = TGM;
         end
      endcase
`ifdef TL_NIGHT_FLASH_EN
      // night request overrides any expiry on the same step
      if (step && night_mode && state <= AR2) begin
         state_n    = FLASH;
         cnt_n      = '0;
         flash_ph_n = 1'b1;
      end
`endif
      if (state_n == SG && state != SG)
         side_pend_n = side_req;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state     <= MG;
         cnt       <= TGM;
         tick_d    <= 1'b0;
         side_pend <= 1'b0;
`ifdef TL_NIGHT_FLASH_EN
         flash_ph  <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         tick_d    <= tick_in;
         side_pend <= side_pend_n;
`ifdef TL_NIGHT_FLASH_EN
         flash_ph  <= flash_ph_n;
`endif
      end
   end

   always_comb begin
      main_light = 3'b100;
      side_light = 3'b100;
      unique case (state)
         MG: main_light = 3'b001;
         MY: main_light = 3'b010;
         SG: side_light = 3'b001;
         SY: side_light = 3'b010;
`ifdef TL_NIGHT_FLASH_EN
         FLASH: begin
            main_light = {1'b0, flash_ph, 1'b0};
            side_light = {1'b0, flash_ph, 1'b0};
         end
`endif
         default: ;
      endcase
   end

   assign count_out = cnt;
   assign state_out = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboarded bench for traffic_light_ctrl: phase table plus corner cases.
// Night expectations follow TL_NIGHT_FLASH_EN.
module tb_traffic_light_ctrl;

   localparam int W = 8;

   logic         clk_in = 1'b0;
   logic         rst_n = 1'b0;
   logic         tick_in = 1'b0;
   logic         side_req = 1'b0;
   logic         night_mode = 1'b0;
   logic [2:0]   main_light, side_light, state_out;
   logic [W-1:0] count_out;

   always #5 clk_in = ~clk_in;

   traffic_light_ctrl #(
      .CNT_W(W), .T_GREEN_MAIN(3), .T_GREEN_SIDE(2),
      .T_YELLOW(2), .T_ALLRED(1)
   ) dut (
      .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in),
      .side_req(side_req), .night_mode(night_mode),
      .main_light(main_light), .side_light(side_light),
      .count_out(count_out), .state_out(state_out)
   );

   typedef struct {
      int           tag;
      logic [2:0]   st;
      logic [W-1:0] cnt;
      logic [2:0]   ml;
      logic [2:0]   sl;
   } exp_t;

   // req: 0 low, 1 held high, 2 one-clock pulse before the step
   typedef struct {
      int           req;
      logic [2:0]   st;
      logic [W-1:0] cnt;
   } vec_t;

   exp_t sb[$];
   vec_t vt[27];
   int   total = 0;
   int   bad = 0;

   function automatic logic [5:0] lights(input logic [2:0] st);
      case (st)
         3'd0:    return {3'b001, 3'b100};
         3'd1:    return {3'b010, 3'b100};
         3'd3:    return {3'b100, 3'b001};
         3'd4:    return {3'b100, 3'b010};
         default: return {3'b100, 3'b100};
      endcase
   endfunction

   task automatic push_raw(input int tag, input logic [2:0] st,
                           input logic [W-1:0] c,
                           input logic [2:0] ml, input logic [2:0] sl);
      exp_t e;
      e.tag = tag; e.st = st; e.cnt = c; e.ml = ml; e.sl = sl;
      sb.push_back(e);
   endtask

   task automatic push(input int tag, input logic [2:0] st,
                       input logic [W-1:0] c);
      logic [5:0] l;
      l = lights(st);
      push_raw(tag, st, c, l[5:3], l[2:0]);
   endtask

   task automatic check();
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL scoreboard underflow at %0t", $time);
         return;
      end
      e = sb.pop_front();
      if (state_out !== e.st || count_out !== e.cnt ||
          main_light !== e.ml || side_light !== e.sl) begin
         bad++;
         $display("FAIL check %0d: got st=%0d cnt=%0d main=%b side=%b, want st=%0d cnt=%0d main=%b side=%b",
                  e.tag, state_out, count_out, main_light, side_light,
                  e.st, e.cnt, e.ml, e.sl);
      end
   endtask

   task automatic do_step(input int req);
      if (req == 2) begin
         @(negedge clk_in) side_req = 1'b1;
         @(negedge clk_in) side_req = 1'b0;
      end else begin
         side_req = (req == 1);
      end
      @(negedge clk_in) tick_in = 1'b1;
      @(negedge clk_in);
      @(negedge clk_in) tick_in = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      rst_n = 1'b0; tick_in = 1'b0; side_req = 1'b0; night_mode = 1'b0;
      @(negedge clk_in) rst_n = 1'b1;
   endtask

   task automatic go_sg(input int base);
      logic [2:0]   s[6];
      logic [W-1:0] c[6];
      s = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3};
      c = '{8'd2, 8'd1, 8'd2, 8'd1, 8'd1, 8'd2};
      for (int i = 0; i < 6; i++) begin
         push(base + i, s[i], c[i]);
         do_step(1);
         check();
      end
   endtask

   initial begin
      vt[0]  = '{1, 3'd0, 8'd2};
      vt[1]  = '{1, 3'd0, 8'd1};
      vt[2]  = '{1, 3'd1, 8'd2};
      vt[3]  = '{1, 3'd1, 8'd1};
      vt[4]  = '{1, 3'd2, 8'd1};
      vt[5]  = '{0, 3'd3, 8'd2};
      vt[6]  = '{0, 3'd3, 8'd1};
      vt[7]  = '{0, 3'd4, 8'd2};
      vt[8]  = '{0, 3'd4, 8'd1};
      vt[9]  = '{0, 3'd5, 8'd1};
      vt[10] = '{0, 3'd0, 8'd3};
      vt[11] = '{0, 3'd0, 8'd2};
      vt[12] = '{0, 3'd0, 8'd1};
      vt[13] = '{0, 3'd0, 8'd1};
      vt[14] = '{0, 3'd0, 8'd1};
      vt[15] = '{2, 3'd1, 8'd2};
      vt[16] = '{0, 3'd1, 8'd1};
      vt[17] = '{0, 3'd2, 8'd1};
      vt[18] = '{0, 3'd3, 8'd2};
      vt[19] = '{0, 3'd3, 8'd1};
      vt[20] = '{0, 3'd4, 8'd2};
      vt[21] = '{0, 3'd4, 8'd1};
      vt[22] = '{0, 3'd5, 8'd1};
      vt[23] = '{0, 3'd0, 8'd3};
      vt[24] = '{0, 3'd0, 8'd2};
      vt[25] = '{0, 3'd0, 8'd1};
      vt[26] = '{0, 3'd0, 8'd1};

      repeat (2) @(negedge clk_in);
      push(0, 3'd0, 8'd3);
      check();
      rst_n = 1'b1;

      for (int i = 0; i < 27; i++) begin
         push(i + 1, vt[i].st, vt[i].cnt);
         do_step(vt[i].req);
         check();
      end

      do_reset();
      go_sg(50);
      night_mode = 1'b1;
`ifdef TL_NIGHT_FLASH_EN
      push_raw(100, 3'd6, 8'd0, 3'b010, 3'b010);
      do_step(1); check();
      push_raw(101, 3'd6, 8'd0, 3'b000, 3'b000);
      do_step(1); check();
      push_raw(102, 3'd6, 8'd0, 3'b010, 3'b010);
      do_step(1); check();
`else
      push(100, 3'd3, 8'd1);
      do_step(1); check();
      push(101, 3'd4, 8'd2);
      do_step(1); check();
      push(102, 3'd4, 8'd1);
      do_step(1); check();
`endif
      night_mode = 1'b0;
      push(103, 3'd5, 8'd1);
      do_step(1); check();
      push(104, 3'd0, 8'd3);
      do_step(1); check();

      go_sg(150);
      @(negedge clk_in);
      #2 rst_n = 1'b0;
      #1 push(200, 3'd0, 8'd3);
      check();
      tick_in = 1'b1;
      side_req = 1'b0;
      @(negedge clk_in) rst_n = 1'b1;
      repeat (20) @(negedge clk_in);
      push(201, 3'd0, 8'd2);
      check();
      tick_in = 1'b0;
      repeat (4) @(negedge clk_in);
      push(202, 3'd0, 8'd2);
      check();
      push(203, 3'd0, 8'd1);
      do_step(0);
      check();

      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard leftover: got %0d entries, want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
